// File: rtl/cardinal_pkg.sv
// -----------------------------------------------------------------------------
// cardinal_pkg
// Shared definitions for the cardinal NIC/router link.
//   PAC_WIDTH_DEFAULT : default packet width in bits
//   VC_BIT            : packet bit that names the virtual channel
//   polarity_e        : link polarity / VC identifiers (EVEN = 0, ODD = 1)
// -----------------------------------------------------------------------------
package cardinal_pkg;

    localparam int PAC_WIDTH_DEFAULT = 64;
    localparam int VC_BIT            = 0;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } polarity_e;

endpackage

// File: rtl/cardinal_vc_buf.sv
// -----------------------------------------------------------------------------
// cardinal_vc_buf
// Two one-entry buffers, one per virtual channel, sharing a write port and a
// read port that are each steered by a VC index.
//   clk, reset      : clock, asynchronous active-low reset
//   wr_en/wr_vc     : store wr_data into the slot wr_vc and mark it full
//   rd_en/rd_vc     : release the slot rd_vc
//   full[1:0]       : per-VC occupancy
//   rd_data         : contents of slot rd_vc
// -----------------------------------------------------------------------------
module cardinal_vc_buf
    import cardinal_pkg::*;
#(
    parameter int WIDTH = PAC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_vc,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_vc,
    output logic [1:0]       full,
    output logic [WIDTH-1:0] rd_data
);

    logic [1:0]            full_q, full_d;
    logic [1:0][WIDTH-1:0] data_q, data_d;

    // A released slot also has its data zeroed so an empty slot never shows
    // a stale packet. The caller never reads and writes the same VC in one
    // cycle; if it did, the write would win.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rd_en) begin
            full_d[rd_vc] = 1'b0;
            data_d[rd_vc] = '0;
        end
        if (wr_en) begin
            full_d[wr_vc] = 1'b1;
            data_d[wr_vc] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full    = full_q;
    assign rd_data = data_q[rd_vc];

endmodule

// File: rtl/cardinal_router_local_port.sv
// -----------------------------------------------------------------------------
// cardinal_router_local_port
// Router-side endpoint of the NIC-router link. Packets from the NIC are
// buffered per VC and offered to the crossbar; packets from the crossbar are
// buffered per VC and delivered to the NIC. With p = net_polarity, fills use
// VC ~p and drains use VC p, so fill and drain never touch the same slot.
//   clk, reset                        : clock, asynchronous active-low reset
//   net_polarity                      : current link polarity
//   net_so/net_ro/net_do              : NIC -> port packet handshake
//   net_si/net_ri/net_di              : port -> NIC packet handshake
//   sw_out_valid/sw_out_ready/_data   : ingress packet to the crossbar
//   sw_in_valid/sw_in_ready/_data     : egress packet from the crossbar
//   vc_err                            : sticky wrong-VC indication
// -----------------------------------------------------------------------------
module cardinal_router_local_port
    import cardinal_pkg::*;
#(
    parameter int PAC_WIDTH = PAC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 net_polarity,
    input  logic                 net_so,
    output logic                 net_ro,
    input  logic [PAC_WIDTH-1:0] net_do,
    output logic                 net_si,
    input  logic                 net_ri,
    output logic [PAC_WIDTH-1:0] net_di,
    output logic                 sw_out_valid,
    input  logic                 sw_out_ready,
    output logic [PAC_WIDTH-1:0] sw_out_data,
    input  logic                 sw_in_valid,
    output logic                 sw_in_ready,
    input  logic [PAC_WIDTH-1:0] sw_in_data,
    output logic                 vc_err
);

    logic                 drain_vc;
    logic                 fill_vc;
    logic [1:0]           in_full;
    logic [1:0]           eg_full;
    logic [PAC_WIDTH-1:0] in_rd_data;
    logic [PAC_WIDTH-1:0] eg_rd_data;
    logic                 in_offer, in_wr, in_bad, in_rd;
    logic                 eg_offer, eg_wr, eg_bad, eg_rd;
    logic                 vc_err_q, vc_err_d;

    assign drain_vc = net_polarity;
    assign fill_vc  = ~net_polarity;

    // Ingress: net_ro depends only on state, polarity and reset, never on
    // net_do. A packet offered while net_ro=1 is either stored or, if its VC
    // bit is wrong, dropped and flagged.
    assign net_ro       = reset & ~in_full[fill_vc];
    assign in_offer     = net_so & net_ro;
    assign in_wr        = in_offer & (net_do[VC_BIT] == fill_vc);
    assign in_bad       = in_offer & (net_do[VC_BIT] != fill_vc);
    assign sw_out_valid = in_full[drain_vc];
    assign sw_out_data  = sw_out_valid ? in_rd_data : '0;
    assign in_rd        = sw_out_valid & sw_out_ready;

    // Egress: delivery to the NIC is a single-cycle handshake, so the slot
    // is released on the same edge net_si is high. Gating with reset makes
    // net_si fall together with reset.
    assign sw_in_ready = reset & ~eg_full[fill_vc];
    assign eg_offer    = sw_in_valid & sw_in_ready;
    assign eg_wr       = eg_offer & (sw_in_data[VC_BIT] == fill_vc);
    assign eg_bad      = eg_offer & (sw_in_data[VC_BIT] != fill_vc);
    assign net_si      = reset & eg_full[drain_vc] & net_ri;
    assign net_di      = net_si ? eg_rd_data : '0;
    assign eg_rd       = net_si;

    cardinal_vc_buf #(
        .WIDTH (PAC_WIDTH)
    ) u_ingress_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_wr),
        .wr_vc   (fill_vc),
        .wr_data (net_do),
        .rd_en   (in_rd),
        .rd_vc   (drain_vc),
        .full    (in_full),
        .rd_data (in_rd_data)
    );

    cardinal_vc_buf #(
        .WIDTH (PAC_WIDTH)
    ) u_egress_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (eg_wr),
        .wr_vc   (fill_vc),
        .wr_data (sw_in_data),
        .rd_en   (eg_rd),
        .rd_vc   (drain_vc),
        .full    (eg_full),
        .rd_data (eg_rd_data)
    );

    // Wrong-VC error is sticky until reset.
    always_comb begin
        vc_err_d = vc_err_q | in_bad | eg_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_err_q <= 1'b0;
        end else begin
            vc_err_q <= vc_err_d;
        end
    end

    assign vc_err = vc_err_q;

endmodule

// File: tb/tb_cardinal_router_local_port.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_cardinal_router_local_port
// Directed scenarios with literal expectations, then randomized traffic. A
// per-VC slot model is checked against the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_cardinal_router_local_port;

    logic        clk;
    logic        reset;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        sw_out_valid;
    logic        sw_out_ready;
    logic [63:0] sw_out_data;
    logic        sw_in_valid;
    logic        sw_in_ready;
    logic [63:0] sw_in_data;
    logic        vc_err;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] PKT_A = 64'hA5A5_5A5A_5A5A_5A5B;
    localparam logic [63:0] PKT_B = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_C = 64'hFEDC_BA98_7654_3211;
    localparam logic [63:0] PKT_D = 64'h0000_0000_0000_1234;
    localparam logic [63:0] PKT_E = 64'hDEAD_BEEF_0000_0010;
    localparam logic [63:0] PKT_F = 64'h0F0F_0F0F_0F0F_0F0E;
    localparam logic [63:0] PKT_G = 64'h7777_0000_0000_0001;

    cardinal_router_local_port #(
        .PAC_WIDTH (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .sw_out_valid (sw_out_valid),
        .sw_out_ready (sw_out_ready),
        .sw_out_data  (sw_out_data),
        .sw_in_valid  (sw_in_valid),
        .sw_in_ready  (sw_in_ready),
        .sw_in_data   (sw_in_data),
        .vc_err       (vc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Move to the next cycle; polarity flips every cycle.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        net_polarity = ~net_polarity;
    endtask

    // Drive this cycle's inputs and let the combinational outputs settle.
    task automatic applyStimulus(input logic so, input logic [63:0] d, input logic sor,
                                 input logic siv, input logic [63:0] sd, input logic ri);
        net_so       = so;
        net_do       = d;
        sw_out_ready = sor;
        sw_in_valid  = siv;
        sw_in_data   = sd;
        net_ri       = ri;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " net_ro"},       {63'b0, net_ro},       64'd0);
        checkOutput({tag, " net_si"},       {63'b0, net_si},       64'd0);
        checkOutput({tag, " net_di"},       net_di,                64'd0);
        checkOutput({tag, " sw_out_valid"}, {63'b0, sw_out_valid}, 64'd0);
        checkOutput({tag, " sw_out_data"},  sw_out_data,           64'd0);
        checkOutput({tag, " sw_in_ready"},  {63'b0, sw_in_ready},  64'd0);
        checkOutput({tag, " vc_err"},       {63'b0, vc_err},       64'd0);
    endtask

    // Reference model: one slot per VC on each side plus a sticky error bit.
    // Outputs are derived from the slots and the current polarity; slots
    // update from the inputs that the next rising edge will sample.
    bit          m_in_full [2];
    logic [63:0] m_in_data [2];
    bit          m_eg_full [2];
    logic [63:0] m_eg_data [2];
    bit          m_err;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_in_full[i] = 1'b0;
                m_in_data[i] = '0;
                m_eg_full[i] = 1'b0;
                m_eg_data[i] = '0;
            end
            m_err = 1'b0;
        end else begin
            int          dv;
            int          fv;
            bit          e_ro, e_sov, e_sir, e_si;
            logic [63:0] e_sod, e_di;
            dv    = net_polarity ? 1 : 0;
            fv    = 1 - dv;
            e_ro  = !m_in_full[fv];
            e_sov = m_in_full[dv];
            e_sod = e_sov ? m_in_data[dv] : 64'd0;
            e_sir = !m_eg_full[fv];
            e_si  = m_eg_full[dv] && net_ri;
            e_di  = e_si ? m_eg_data[dv] : 64'd0;

            checkOutput("model net_ro",       {63'b0, net_ro},       {63'b0, e_ro});
            checkOutput("model sw_out_valid", {63'b0, sw_out_valid}, {63'b0, e_sov});
            checkOutput("model sw_out_data",  sw_out_data,           e_sod);
            checkOutput("model sw_in_ready",  {63'b0, sw_in_ready},  {63'b0, e_sir});
            checkOutput("model net_si",       {63'b0, net_si},       {63'b0, e_si});
            checkOutput("model net_di",       net_di,                e_di);
            checkOutput("model vc_err",       {63'b0, vc_err},       {63'b0, m_err});

            if (e_sov && sw_out_ready) begin
                m_in_full[dv] = 1'b0;
            end
            if (e_si) begin
                m_eg_full[dv] = 1'b0;
            end
            if (net_so && e_ro) begin
                if (int'(net_do[0]) == fv) begin
                    m_in_full[fv] = 1'b1;
                    m_in_data[fv] = net_do;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (sw_in_valid && e_sir) begin
                if (int'(sw_in_data[0]) == fv) begin
                    m_eg_full[fv] = 1'b1;
                    m_eg_data[fv] = sw_in_data;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [63:0] sd;
        reset        = 1'b0;
        net_polarity = 1'b0;
        net_so       = 1'b1;
        net_do       = PKT_A;
        sw_out_ready = 1'b0;
        sw_in_valid  = 1'b1;
        sw_in_data   = PKT_D;
        net_ri       = 1'b1;

        // Outputs held low while reset is asserted, even with live inputs.
        #2;
        checkAllZero("reset");

        @(posedge clk);
        @(posedge clk);
        #1;
        net_so      = 1'b0;
        sw_in_valid = 1'b0;
        net_ri      = 1'b0;
        reset       = 1'b1;
        net_polarity = 1'b0;

        // C0 p=0: release, then an odd packet that drains without stalling.
        applyStimulus(1'b1, PKT_A, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("release net_ro",      {63'b0, net_ro},       64'd1);
        checkOutput("release sw_in_ready", {63'b0, sw_in_ready},  64'd1);
        checkOutput("release sw_out_valid",{63'b0, sw_out_valid}, 64'd0);
        checkOutput("release net_si",      {63'b0, net_si},       64'd0);
        nextCycle();   // C1 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("nb valid", {63'b0, sw_out_valid}, 64'd1);
        checkOutput("nb data",  sw_out_data,           PKT_A);
        nextCycle();   // C2 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("nb even empty", {63'b0, sw_out_valid}, 64'd0);
        nextCycle();   // C3 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("nb cleared", {63'b0, sw_out_valid}, 64'd0);

        // Blocking ingress: crossbar not ready, second odd packet refused.
        nextCycle();   // C4 p=0
        applyStimulus(1'b1, PKT_B, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("blk ro first", {63'b0, net_ro}, 64'd1);
        nextCycle();   // C5 p=1
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("blk valid", {63'b0, sw_out_valid}, 64'd1);
        checkOutput("blk data",  sw_out_data,           PKT_B);
        nextCycle();   // C6 p=0
        applyStimulus(1'b1, PKT_C, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("blk ro held", {63'b0, net_ro}, 64'd0);
        nextCycle();   // C7 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("blk data kept", sw_out_data,      PKT_B);
        checkOutput("blk no err",    {63'b0, vc_err},  64'd0);
        nextCycle();   // C8 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("blk ro back", {63'b0, net_ro}, 64'd1);

        // Egress: even packet held while the NIC is not ready.
        nextCycle();   // C9 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, PKT_D, 1'b0);
        checkOutput("eg ready", {63'b0, sw_in_ready}, 64'd1);
        nextCycle();   // C10 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("eg hold si", {63'b0, net_si}, 64'd0);
        checkOutput("eg hold di", net_di,          64'd0);
        nextCycle();   // C11 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("eg full ready", {63'b0, sw_in_ready}, 64'd0);
        nextCycle();   // C12 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("eg hold si2", {63'b0, net_si}, 64'd0);
        nextCycle();   // C13 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("eg odd idle", {63'b0, net_si}, 64'd0);
        nextCycle();   // C14 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("eg deliver si", {63'b0, net_si}, 64'd1);
        checkOutput("eg deliver di", net_di,          PKT_D);
        nextCycle();   // C15 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("eg after ready", {63'b0, sw_in_ready}, 64'd1);

        // VC mismatch on ingress: even packet offered at p=0.
        nextCycle();   // C16 p=0
        applyStimulus(1'b1, PKT_E, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("eg emptied", {63'b0, net_si}, 64'd0);
        nextCycle();   // C17 p=1
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("vc err set",  {63'b0, vc_err},       64'd1);
        checkOutput("vc dropped",  {63'b0, sw_out_valid}, 64'd0);
        nextCycle();   // C18 p=0
        applyStimulus(1'b1, PKT_A, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("vc ro ok", {63'b0, net_ro}, 64'd1);
        nextCycle();   // C19 p=1
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("vc after data", sw_out_data,     PKT_A);
        checkOutput("vc sticky",     {63'b0, vc_err}, 64'd1);

        // Mid-operation reset with both ingress slots and one egress slot full.
        nextCycle();   // C20 p=0
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, PKT_G, 1'b0);
        checkOutput("mid ro", {63'b0, net_ro}, 64'd0);
        nextCycle();   // C21 p=1
        applyStimulus(1'b1, PKT_F, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("mid ro even", {63'b0, net_ro}, 64'd1);
        nextCycle();   // C22 p=0
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("mid even data", sw_out_data, PKT_F);
        nextCycle();   // C23 p=1
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("mid si",   {63'b0, net_si}, 64'd1);
        checkOutput("mid di",   net_di,          PKT_G);
        checkOutput("mid data", sw_out_data,     PKT_A);
        reset = 1'b0;
        #0.5;
        checkAllZero("mid reset");
        reset = 1'b1;
        #0.5;
        checkOutput("mid rel ro",    {63'b0, net_ro},       64'd1);
        checkOutput("mid rel valid", {63'b0, sw_out_valid}, 64'd0);
        checkOutput("mid rel si",    {63'b0, net_si},       64'd0);
        nextCycle();   // C24 p=0
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("mid stale even", {63'b0, sw_out_valid}, 64'd0);
        checkOutput("mid stale si",   {63'b0, net_si},       64'd0);

        // Randomized traffic; occasional wrong-VC packets on both sides.
        for (int n = 0; n < 3000; n++) begin
            nextCycle();
            d  = {$urandom, $urandom};
            sd = {$urandom, $urandom};
            d[0]  = ($urandom_range(0, 63) == 0) ? net_polarity : ~net_polarity;
            sd[0] = ($urandom_range(0, 63) == 0) ? net_polarity : ~net_polarity;
            applyStimulus($urandom_range(0, 1) == 1, d,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1, sd,
                          $urandom_range(0, 3) != 0);
            if (n == 1500) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
